// File: rtl/i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_arbiter
// Purpose  : Round-robin owner of the PMIC i2c_master, one register txn at a time
// Revision : 1.0
// ============================================================================
module i2c_arbiter #(
    parameter int         N_REQ     = 3,
    parameter logic [6:0] I2C_ADDR  = 7'h48,
    parameter int         START_TO  = 16,
    parameter int         TIMEOUT_W = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [8*N_REQ-1:0]   req_subaddr,
    input  logic [8*N_REQ-1:0]   req_wrdata,
    output logic [N_REQ-1:0]     req_grant,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_rddata,
    output logic                 rsp_err,
    output logic [7:0]           m_addr_w_rw,
    output logic [7:0]           m_sub_addr,
    output logic [7:0]           m_wrdata,
    output logic                 m_req,
    input  logic [7:0]           m_rddata,
    input  logic                 m_busy,
    input  logic                 m_nack,
    output logic [2:0]           dbg_state
);

    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TIMEOUT_W-1:0] c_start_last = TIMEOUT_W'(START_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_RESP       = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_ptr_w-1:0]    r_ptr;
    logic [c_ptr_w-1:0]    r_winner;
    logic [c_ptr_w-1:0]    w_pick;
    logic [c_ptr_w:0]      w_idx;
    logic                  w_found;
    logic [N_REQ-1:0]      w_req;
    logic [TIMEOUT_W-1:0]  r_cnt;
    logic                  r_nack_seen;
    logic                  r_err;

    // The requester being answered this cycle still shows req_valid; masking it
    // prevents it from being granted a second, unrequested transaction.
    always_comb begin
        w_req   = req_valid & ~rsp_valid;
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (c_ptr_w+1)'(k);
            if (w_idx >= (c_ptr_w+1)'(N_REQ)) begin
                w_idx = w_idx - (c_ptr_w+1)'(N_REQ);
            end
            if (!w_found && w_req[w_idx[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[c_ptr_w-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_found) w_next = S_ISSUE;
            S_ISSUE:      w_next = S_WAIT_START;
            S_WAIT_START: begin
                if (m_busy) begin
                    w_next = S_WAIT_DONE;
                end else if (r_cnt == c_start_last) begin
                    w_next = S_RESP;
                end
            end
            S_WAIT_DONE:  if (!m_busy || (r_cnt == '1)) w_next = S_RESP;
            S_RESP:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_grant   <= '0;
            rsp_valid   <= '0;
            rsp_rddata  <= '0;
            rsp_err     <= 1'b0;
            m_addr_w_rw <= {I2C_ADDR, 1'b0};
            m_sub_addr  <= '0;
            m_wrdata    <= '0;
            m_req       <= 1'b0;
            r_ptr       <= '0;
            r_winner    <= '0;
            r_cnt       <= '0;
            r_nack_seen <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            m_req     <= 1'b0;
            rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_winner    <= w_pick;
                        req_grant   <= N_REQ'(1) << w_pick;
                        m_addr_w_rw <= {I2C_ADDR, req_rw[w_pick]};
                        m_sub_addr  <= req_subaddr[{w_pick, 3'b000} +: 8];
                        m_wrdata    <= req_wrdata[{w_pick, 3'b000} +: 8];
                        m_req       <= 1'b1;
                        r_ptr       <= (w_pick == c_ptr_w'(N_REQ - 1)) ? '0 : w_pick + 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_cnt       <= '0;
                    r_nack_seen <= 1'b0;
                    r_err       <= 1'b0;
                end
                S_WAIT_START: begin
                    if (m_busy) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_start_last) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (m_nack) begin
                        r_nack_seen <= 1'b1;
                    end
                    if (!m_busy) begin
                        r_err <= r_nack_seen | m_nack;
                        if (m_addr_w_rw[0]) begin
                            rsp_rddata <= m_rddata;
                        end
                    end else if (r_cnt == '1) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= N_REQ'(1) << r_winner;
                    rsp_err   <= r_err;
                    req_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_arbiter
// Purpose  : Directed self-checking bench for i2c_arbiter with a small master model
// Revision : 1.0
// ============================================================================
module tb_i2c_arbiter;

    localparam int N_REQ    = 3;
    localparam int START_TO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_rw = '0;
    logic [8*N_REQ-1:0]   req_subaddr = '0;
    logic [8*N_REQ-1:0]   req_wrdata = '0;
    logic [N_REQ-1:0]     req_grant;
    logic [N_REQ-1:0]     rsp_valid;
    logic [7:0]           rsp_rddata;
    logic                 rsp_err;
    logic [7:0]           m_addr_w_rw;
    logic [7:0]           m_sub_addr;
    logic [7:0]           m_wrdata;
    logic                 m_req;
    logic [7:0]           m_rddata;
    logic                 m_busy;
    logic                 m_nack;
    logic [2:0]           dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int mdl_mode = 0;     // 0 normal, 1 nack mid-transfer, 2 never busy
    logic [3:0] mdl_cnt;

    i2c_arbiter #(
        .N_REQ     (N_REQ),
        .I2C_ADDR  (7'h48),
        .START_TO  (START_TO),
        .TIMEOUT_W (22)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_rw      (req_rw),
        .req_subaddr (req_subaddr),
        .req_wrdata  (req_wrdata),
        .req_grant   (req_grant),
        .rsp_valid   (rsp_valid),
        .rsp_rddata  (rsp_rddata),
        .rsp_err     (rsp_err),
        .m_addr_w_rw (m_addr_w_rw),
        .m_sub_addr  (m_sub_addr),
        .m_wrdata    (m_wrdata),
        .m_req       (m_req),
        .m_rddata    (m_rddata),
        .m_busy      (m_busy),
        .m_nack      (m_nack),
        .dbg_state   (dbg_state)
    );

    always #15 clk = ~clk;

    // Master model: busy for 10 cycles starting the cycle after m_req.
    assign m_rddata = 8'h80;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_nack  <= 1'b0;
            mdl_cnt <= '0;
        end else begin
            m_nack <= 1'b0;
            if (m_req && mdl_mode != 2) begin
                m_busy  <= 1'b1;
                mdl_cnt <= 4'd10;
            end else if (m_busy) begin
                mdl_cnt <= mdl_cnt - 4'd1;
                if (mdl_cnt == 4'd1) m_busy <= 1'b0;
                if (mdl_mode == 1 && mdl_cnt == 4'd5) m_nack <= 1'b1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input int idx, input logic rw, input logic [7:0] sub,
                           input logic [7:0] wr, input logic exp_err,
                           input logic [7:0] exp_rd, input string tag);
        int n;
        logic [N_REQ-1:0] onehot;
        onehot = N_REQ'(1) << idx;
        req_rw[idx]              = rw;
        req_subaddr[8*idx +: 8]  = sub;
        req_wrdata[8*idx +: 8]   = wr;
        req_valid[idx]           = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_req && n < 20);
        check_eq({tag, "_mreq_lat"}, n, 1);
        check_eq({tag, "_grant"}, req_grant, onehot);
        check_eq({tag, "_addr"}, m_addr_w_rw, {7'h48, rw});
        check_eq({tag, "_sub"}, m_sub_addr, sub);
        if (!rw) check_eq({tag, "_wrdata"}, m_wrdata, wr);
        @(negedge clk);
        check_eq({tag, "_mreq_pulse"}, m_req, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 100);
        check_eq({tag, "_rsp_valid"}, rsp_valid, onehot);
        check_eq({tag, "_rsp_err"}, rsp_err, exp_err);
        check_eq({tag, "_grant_clr"}, req_grant, 0);
        if (rw) check_eq({tag, "_rddata"}, rsp_rddata, exp_rd);
        req_valid[idx] = 1'b0;
        @(negedge clk);
        check_eq({tag, "_rsp_pulse"}, rsp_valid, 0);
    endtask

    initial begin
        #(30 * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int gi;
        int got[$];
        logic [N_REQ-1:0] prev;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_grant", req_grant, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_mreq", m_req, 0);
        check_eq("rst_addr", m_addr_w_rw, 8'h90);
        check_eq("rst_sub", m_sub_addr, 0);
        check_eq("rst_rddata", rsp_rddata, 0);
        check_eq("rst_err", rsp_err, 0);
        check_eq("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // All three requesters held: rotating order, one-hot grant
        req_valid = 3'b111;
        bad  = 0;
        prev = '0;
        n    = 0;
        while (got.size() < 6 && n < 400) begin
            @(negedge clk);
            n++;
            if ($countones(req_grant) > 1) bad++;
            if (req_grant != '0 && prev == '0) begin
                gi = -1;
                for (int j = 0; j < N_REQ; j++) if (req_grant[j]) gi = j;
                got.push_back(gi);
            end
            prev = req_grant;
        end
        req_valid = '0;
        check_eq("rr_count", got.size(), 6);
        for (int i = 0; i < got.size(); i++) check_eq("rr_order", got[i], i % 3);
        check_eq("rr_onehot", bad, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 100);
        check_eq("rr_last_rsp", rsp_valid, 3'b100);
        repeat (2) @(negedge clk);

        // Single write and read
        run_txn(0, 1'b0, 8'h08, 8'd143, 1'b0, 8'h00, "wr0");
        run_txn(2, 1'b1, 8'h0a, 8'h00, 1'b0, 8'h80, "rd2");

        // NACK then clean transaction
        mdl_mode = 1;
        run_txn(1, 1'b0, 8'h11, 8'h5a, 1'b1, 8'h00, "nack1");
        mdl_mode = 0;
        run_txn(1, 1'b0, 8'h12, 8'ha5, 1'b0, 8'h00, "clean1");

        // Master never goes busy: start timeout
        mdl_mode = 2;
        req_rw[0] = 1'b0;
        req_valid[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_req && n < 20);
        check_eq("to_mreq", m_req, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 100);
        check_eq("to_latency", n, START_TO + 2);
        check_eq("to_rsp_valid", rsp_valid, 3'b001);
        check_eq("to_rsp_err", rsp_err, 1);
        req_valid = '0;
        mdl_mode = 0;
        repeat (2) @(negedge clk);

        // Reset during WAIT_DONE
        req_rw[1] = 1'b1;
        req_subaddr[15:8] = 8'h3c;
        req_valid[1] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_req && n < 20);
        repeat (3) @(negedge clk);
        check_eq("mid_state", dbg_state, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_grant", req_grant, 0);
        check_eq("mid_rst_mreq", m_req, 0);
        check_eq("mid_rst_addr", m_addr_w_rw, 8'h90);
        check_eq("mid_rst_sub", m_sub_addr, 0);
        check_eq("mid_rst_rddata", rsp_rddata, 0);
        check_eq("mid_rst_err", rsp_err, 0);
        check_eq("mid_rst_state", dbg_state, 0);
        rst_n = 1'b1;
        req_valid = '0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid != '0) bad++;
        end
        check_eq("mid_no_rsp", bad, 0);
        req_valid = 3'b110;
        @(negedge clk);
        check_eq("mid_ptr_restart", req_grant, 3'b010);
        req_valid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 100);
        check_eq("mid_drop_rsp", rsp_valid, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
